pe_row_drain: RTL and testbench

Downstream collector for one row of the PE mesh. On a capture strobe it snapshots the `o_PE` words of all `SQRT_N` PEs in the row and streams them out one per cycle, column 0 (the `FIRST_IN_ROW` PE) first, over a valid/ready handshake. It optionally drops `MAX_INT` padding words and flags the last emitted word of each row. It sits between the PE row and the result sink or host readout.

---
 rtl/pe_row_drain.sv | 101 ++++++++++
 tb/tb_pe_row_drain.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pe_row_drain.sv
// Collector for one PE-mesh row: snapshots the row on a capture strobe and
// streams the words out column 0 first over valid/ready, optionally dropping padding.
//
// state | meaning
// IDLE  | no row held; capture accepted immediately
// EMIT  | walking row_q; skip cycles for masked words, handshake for the rest
module pe_row_drain #(
  parameter int SQRT_N = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1,
  parameter bit SKIP_MAX = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_capture,
  input  logic [SQRT_N*(ADDR_WIDTH+DATA_WIDTH)-1:0] i_row,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0]          o_data,
  output logic                                      o_valid,
  input  logic                                      i_ready,
  output logic                                      o_last,
  output logic                                      o_busy,
  output logic                                      o_overrun
);

  localparam int W = ADDR_WIDTH + DATA_WIDTH;
  localparam int IDX_W = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                state, state_n;
  logic [SQRT_N*W-1:0]   row_q, row_n;
  logic [SQRT_N-1:0]     mask_q, mask_n, new_mask;
  logic [IDX_W-1:0]      idx, idx_n;
  logic                  overrun_q, overrun_n;
  logic [W-1:0]          cur_word;
  logic                  higher_set;
  logic                  complete;
  logic                  accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_q     <= '0;
      mask_q    <= '0;
      idx       <= '0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      row_q     <= row_n;
      mask_q    <= mask_n;
      idx       <= idx_n;
      overrun_q <= overrun_n;
    end
  end

  // Word select and "anything left above idx" scan, written as loops so the
  // index never has to be multiplied out to a bit offset.
  always_comb begin
    cur_word   = '0;
    higher_set = 1'b0;
    new_mask   = '1;
    for (int k = 0; k < SQRT_N; k++) begin
      if (int'(idx) == k) cur_word = row_q[k*W +: W];
      if (k > int'(idx)) higher_set = higher_set | mask_q[k];
      if (SKIP_MAX) new_mask[k] = (i_row[k*W +: W] != MAX_INT);
    end
  end

  always_comb begin
    o_busy    = (state == EMIT);
    o_valid   = o_busy && mask_q[idx];
    o_last    = o_valid && !higher_set;
    o_data    = o_valid ? cur_word : '0;
    o_overrun = overrun_q;

    complete  = o_valid && i_ready && o_last;
    accept    = i_capture && ((state == IDLE) || complete);

    state_n   = state;
    row_n     = row_q;
    mask_n    = mask_q;
    idx_n     = idx;
    overrun_n = overrun_q | (i_capture && (state == EMIT) && !complete);

    if (accept) begin
      row_n   = i_row;
      mask_n  = new_mask;
      idx_n   = '0;
      state_n = (|new_mask) ? EMIT : IDLE;
    end else if (state == EMIT) begin
      if (!mask_q[idx]) begin
        idx_n = idx + IDX_W'(1);
      end else if (i_ready) begin
        if (o_last) state_n = IDLE;
        else        idx_n = idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_row_drain.sv
// Bench for pe_row_drain: directed scenarios plus random traffic, two instances
// (padding dropped / kept) each compared against a slot-queue model every cycle.
module tb_pe_row_drain;

  localparam int N = 4;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_capture = 1'b0;
  logic [N*W-1:0] i_row = '0;
  logic           i_ready = 1'b1;

  logic [W-1:0] d1, d0;
  logic         v1, v0, l1, l0, b1, b0, ov1, ov0;

  int n_checks = 0;
  int n_pass = 0;

  int  q1[$];
  int  q0[$];
  bit  mov1 = 1'b0;
  bit  mov0 = 1'b0;

  pe_row_drain #(.SQRT_N(N), .ADDR_WIDTH(3), .DATA_WIDTH(3),
                 .MAX_INT(6'b111111), .SKIP_MAX(1'b1)) dut (
    .clk(clk), .rst(rst), .i_capture(i_capture), .i_row(i_row),
    .o_data(d1), .o_valid(v1), .i_ready(i_ready), .o_last(l1),
    .o_busy(b1), .o_overrun(ov1));

  pe_row_drain #(.SQRT_N(N), .ADDR_WIDTH(3), .DATA_WIDTH(3),
                 .MAX_INT(6'b111111), .SKIP_MAX(1'b0)) dut_keep (
    .clk(clk), .rst(rst), .i_capture(i_capture), .i_row(i_row),
    .o_data(d0), .o_valid(v0), .i_ready(i_ready), .o_last(l0),
    .o_busy(b0), .o_overrun(ov0));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // A captured row becomes a list of cycle slots up to the last kept word:
  // -1 is a skip cycle, anything else is a word waiting for a handshake.
  task automatic model_step(input bit skip, inout int q[$], inout bit ovr);
    bit m_busy, m_valid, m_last, compl;
    int last_k;
    m_busy  = (q.size() > 0);
    m_valid = m_busy && (q[0] >= 0);
    m_last  = m_valid && (q.size() == 1);
    compl   = m_valid && i_ready && m_last;
    if (rst) begin
      q.delete();
      ovr = 1'b0;
    end else if (i_capture && (!m_busy || compl)) begin
      q.delete();
      last_k = -1;
      for (int k = 0; k < N; k++)
        if (!skip || i_row[k*W +: W] != 6'd63) last_k = k;
      for (int k = 0; k <= last_k; k++)
        if (skip && i_row[k*W +: W] == 6'd63) q.push_back(-1);
        else q.push_back(int'(i_row[k*W +: W]));
    end else begin
      if (i_capture) ovr = 1'b1;
      if (m_busy && (q[0] < 0 || i_ready)) void'(q.pop_front());
    end
  endtask

  task automatic compare(input string pfx, input int q[$], input bit ovr,
                         input logic [W-1:0] d, input logic v, input logic l,
                         input logic b, input logic ov);
    bit m_valid;
    m_valid = (q.size() > 0) && (q[0] >= 0);
    check({pfx, "_valid"}, 32'(v), 32'(m_valid));
    check({pfx, "_data"}, 32'(d), m_valid ? 32'(q[0]) : 32'd0);
    check({pfx, "_last"}, 32'(l), 32'(m_valid && q.size() == 1));
    check({pfx, "_busy"}, 32'(b), 32'(q.size() > 0));
    check({pfx, "_overrun"}, 32'(ov), 32'(ovr));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(1'b1, q1, mov1);
    model_step(1'b0, q0, mov0);
    #1;
    compare("skip", q1, mov1, d1, v1, l1, b1, ov1);
    compare("keep", q0, mov0, d0, v0, l0, b0, ov0);
  endtask

  task automatic cyc(input bit cap, input bit rdy, input bit r);
    i_capture = cap;
    i_ready   = rdy;
    rst       = r;
    step();
  endtask

  localparam logic [N*W-1:0] ROW_BASIC = {6'o40, 6'o30, 6'o20, 6'o10};
  localparam logic [N*W-1:0] ROW_SKIP  = {6'd63, 6'd18, 6'd9, 6'd63};
  localparam logic [N*W-1:0] ROW_EMPTY = {6'd63, 6'd63, 6'd63, 6'd63};

  initial begin
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    cyc(0, 1, 0);

    // basic stream
    i_row = ROW_BASIC;
    cyc(1, 1, 0);
    repeat (6) cyc(0, 1, 0);
    check("basic_idle_after", 32'(b1), 32'd0);

    // skip row
    i_row = ROW_SKIP;
    cyc(1, 1, 0);
    check("skip_first_is_gap", 32'(v1), 32'd0);
    repeat (6) cyc(0, 1, 0);

    // backpressure on the second word
    i_row = ROW_BASIC;
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    check("bp_held_data", 32'(d1), 32'o20);
    repeat (5) cyc(0, 1, 0);

    // overrun during the second word, then back-to-back in the completing cycle
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    check("ovr_set", 32'(ov1), 32'd1);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    check("b2b_first_word", 32'(d1), 32'o10);
    repeat (6) cyc(0, 1, 0);

    // empty row, then a normal capture
    i_row = ROW_EMPTY;
    cyc(1, 1, 0);
    check("empty_busy", 32'(b1), 32'd0);
    repeat (3) cyc(0, 1, 0);
    i_row = ROW_BASIC;
    cyc(1, 1, 0);
    repeat (6) cyc(0, 1, 0);

    // reset mid-row, then restart
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    check("rst_overrun", 32'(ov1), 32'd0);
    cyc(1, 1, 0);
    check("restart_col0", 32'(d1), 32'o10);
    repeat (6) cyc(0, 1, 0);

    // random traffic, including capture/reset collisions
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < N; k++)
        i_row[k*W +: W] = ($urandom_range(2) == 0) ? 6'd63 : 6'($urandom_range(63));
      cyc(($urandom_range(5) == 0), ($urandom_range(3) != 0), ($urandom_range(60) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
